// File: rtl/prescaler_ctrl_if.sv
// prescaler_ctrl_if: valid/ready configuration channel carrying a new half-period
interface prescaler_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_half;
  modport master (output cfg_valid, output cfg_half, input cfg_ready);
  modport slave (input cfg_valid, input cfg_half, output cfg_ready);
endinterface

// File: rtl/prescaler_ctrl.sv
// prescaler_ctrl: glitch-free programmable clock prescaler; define PRESCALER_CTRL_EDGECNT_EN to build the rising-edge counter
module prescaler_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEFAULT_HALF = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  prescaler_ctrl_if.slave  cfg,
  output logic [WIDTH-1:0] active_half,
  output logic             running,
  output logic             slow_level,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [WIDTH-1:0] edge_count
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2;
  logic [1:0] state, state_n;
  logic [WIDTH-1:0] counter, pend_half, cfg_clamped;
  logic pending, xfer, start_run, quit_low, boundary, rise, fall, apply;
  // Decode boundary, toggles, handshake and next state from the registered state
  always_comb begin
    start_run = state == IDLE && start && !stop;
    quit_low = state == RUN && stop && !slow_level;
    boundary = state != IDLE && counter == active_half - WIDTH'(1);
    rise = boundary && !slow_level && !quit_low;
    fall = boundary && slow_level;
    apply = pending && (rise || fall || state == IDLE);
    xfer = cfg.cfg_valid && !pending;
    cfg_clamped = cfg.cfg_half == '0 ? WIDTH'(1) : cfg.cfg_half;
    state_n = state == IDLE ? (start_run ? RUN : IDLE)
            : quit_low || (fall && (state == STOPPING || stop)) ? IDLE
            : state == RUN ? (stop ? STOPPING : RUN)
            : state == STOPPING ? STOPPING : IDLE;
  end
  // Sequencer, half-period counter, divided level, strobes and config registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      counter <= '0;
      slow_level <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      active_half <= WIDTH'(DEFAULT_HALF);
      pend_half <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      counter <= state == IDLE || quit_low || boundary ? '0 : counter + WIDTH'(1);
      slow_level <= rise || (slow_level && !fall);
      rise_tick <= rise;
      fall_tick <= fall;
      active_half <= apply ? pend_half : xfer && state == IDLE ? cfg_clamped : active_half;
      pend_half <= xfer && state != IDLE ? cfg_clamped : pend_half;
      pending <= xfer && state != IDLE ? 1'b1 : apply ? 1'b0 : pending;
    end
  assign cfg.cfg_ready = !pending;
  assign running = state != IDLE;
`ifdef PRESCALER_CTRL_EDGECNT_EN
  // Count rising toggles of the divided level; restart from zero on every start
  always_ff @(posedge clock or posedge reset)
    if (reset) edge_count <= '0;
    else edge_count <= start_run ? '0 : rise ? edge_count + WIDTH'(1) : edge_count;
`else
  assign edge_count = '0;
`endif
endmodule

// File: tb/tb_prescaler_ctrl.sv
// tb_prescaler_ctrl: directed scenarios plus random stimulus checked against a toggle-time reference model
module tb_prescaler_ctrl;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [15:0] active_half, edge_count;
  logic running, slow_level, rise_tick, fall_tick;
  logic [36:0] obs;
  int checks = 0, errors = 0;
  prescaler_ctrl_if #(.WIDTH(16)) cfg_if ();
  prescaler_ctrl #(.WIDTH(16), .DEFAULT_HALF(2)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .cfg(cfg_if),
    .active_half(active_half), .running(running), .slow_level(slow_level),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .edge_count(edge_count)
  );
  always #5 clock = ~clock;
  assign obs = {running, slow_level, rise_tick, fall_tick, cfg_if.cfg_ready, active_half, edge_count};

  // Reference model: mode (0 idle, 1 run, 2 stopping), level, absolute edge of next toggle
  int m_st, m_h, m_pv, m_edges;
  bit m_lvl, m_pend, m_rt, m_ft;
  longint cyc = 0, m_nb;
`ifdef PRESCALER_CTRL_EDGECNT_EN
  localparam int EXP_EDGES = 10;
`else
  localparam int EXP_EDGES = 0;
`endif

  task automatic model_reset();
    m_st = 0; m_lvl = 0; m_h = 2; m_pv = 0; m_pend = 0; m_edges = 0; m_rt = 0; m_ft = 0; m_nb = 0;
  endtask

  task automatic model_step(input bit st_i, input bit sp_i, input bit v_i, input int h_i);
    int hc;
    bit xfer, bnd;
    hc = h_i == 0 ? 1 : h_i;
    cyc++;
    m_rt = 0; m_ft = 0;
    if (reset) begin model_reset(); return; end
    xfer = v_i && !m_pend;
    if (m_st == 0) begin
      if (m_pend) begin m_h = m_pv; m_pend = 0; end
      else if (xfer) m_h = hc;
      if (st_i && !sp_i) begin m_st = 1; m_nb = cyc + m_h; m_edges = 0; end
    end else begin
      bnd = cyc == m_nb;
      if (m_st == 1 && sp_i && !m_lvl) m_st = 0;
      else if (bnd) begin
        m_lvl = !m_lvl; m_rt = m_lvl; m_ft = !m_lvl;
        if (m_lvl) m_edges = (m_edges + 1) & 32'hFFFF;
        else if (m_st == 2 || sp_i) m_st = 0;
        if (m_pend) begin m_h = m_pv; m_pend = 0; end
        m_nb = cyc + m_h;
      end else if (m_st == 1 && sp_i) m_st = 2;
      if (xfer) begin m_pv = hc; m_pend = 1; end
    end
  endtask

  function automatic logic [36:0] exp_vec();
    logic [15:0] ec;
`ifdef PRESCALER_CTRL_EDGECNT_EN
    ec = 16'(m_edges);
`else
    ec = '0;
`endif
    return {m_st != 0, m_lvl, m_rt, m_ft, !m_pend, 16'(m_h), ec};
  endfunction

  task automatic cycle(input bit st_i, input bit sp_i, input bit v_i, input int h_i);
    start = st_i; stop = sp_i; cfg_if.cfg_valid = v_i; cfg_if.cfg_half = 16'(h_i);
    @(posedge clock);
    model_step(st_i, sp_i, v_i, h_i);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    reset = 1'b0;
    cycle(0, 0, 0, 0);
    checks++; if (slow_level !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL reset_level got slow=%b run=%b want 0 0", slow_level, running); end
    checks++; if (active_half !== 16'd2) begin errors++; $display("FAIL reset_half got %0d want 2", active_half); end
    checks++; if (cfg_if.cfg_ready !== 1'b1 || edge_count !== 16'd0) begin errors++; $display("FAIL reset_cfg got ready=%b ec=%0d want 1 0", cfg_if.cfg_ready, edge_count); end
    checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL reset_model got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_basic();
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0, 0);
      checks++; if (slow_level !== 1'((k / 2) % 2) || rise_tick !== (k % 4 == 2) || running !== 1'b1) begin
        errors++; $display("FAIL basic_k%0d got slow=%b rise=%b run=%b want %b %b 1", k, slow_level, rise_tick, running, 1'((k / 2) % 2), k % 4 == 2);
      end
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL basic_model_k%0d got %h want %h", k, obs, exp_vec()); end
    end
    cycle(0, 1, 0, 0);
    checks++; if (running !== 1'b0 || slow_level !== 1'b0 || fall_tick !== 1'b0) begin errors++; $display("FAIL basic_stop_low got run=%b slow=%b fall=%b want 0 0 0", running, slow_level, fall_tick); end
  endtask

  task automatic test_start_stop_zero_cfg();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 0);
      checks++; if (running !== 1'b0 || slow_level !== 1'b0 || rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
        errors++; $display("FAIL both_idle got run=%b slow=%b rise=%b fall=%b want 0 0 0 0", running, slow_level, rise_tick, fall_tick);
      end
    end
    cycle(0, 0, 1, 0);
    checks++; if (active_half !== 16'd1) begin errors++; $display("FAIL cfg_zero got %0d want 1", active_half); end
    cycle(1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 0, 0, 0);
      checks++; if (slow_level !== 1'(k % 2) || obs !== exp_vec()) begin errors++; $display("FAIL half1_k%0d got slow=%b obs=%h want %b %h", k, slow_level, obs, 1'(k % 2), exp_vec()); end
    end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_edge_count();
    cycle(0, 0, 1, 1);
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 19; k++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    checks++; if (edge_count !== 16'(EXP_EDGES) || running !== 1'b0 || fall_tick !== 1'b1) begin
      errors++; $display("FAIL edgecnt_stop got ec=%0d run=%b fall=%b want %0d 0 1", edge_count, running, fall_tick, EXP_EDGES);
    end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
    checks++; if (edge_count !== 16'(EXP_EDGES)) begin errors++; $display("FAIL edgecnt_hold got %0d want %0d", edge_count, EXP_EDGES); end
    cycle(1, 0, 0, 0);
    checks++; if (edge_count !== 16'd0 || obs !== exp_vec()) begin errors++; $display("FAIL edgecnt_restart got ec=%0d obs=%h want 0 %h", edge_count, obs, exp_vec()); end
    cycle(0, 1, 0, 0);
  endtask

  task automatic test_cfg_midrun();
    cycle(0, 0, 1, 3);
    checks++; if (active_half !== 16'd3) begin errors++; $display("FAIL mid_idle_half got %0d want 3", active_half); end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20 && rise_tick !== 1'b1; i++) cycle(0, 0, 0, 0);
    checks++; if (rise_tick !== 1'b1) begin errors++; $display("FAIL mid_wait_rise got %b want 1", rise_tick); end
    cycle(0, 0, 1, 5);
    checks++; if (cfg_if.cfg_ready !== 1'b0 || active_half !== 16'd3) begin errors++; $display("FAIL mid_pending got ready=%b half=%0d want 0 3", cfg_if.cfg_ready, active_half); end
    cycle(0, 0, 0, 0);
    checks++; if (slow_level !== 1'b1) begin errors++; $display("FAIL mid_high got %b want 1", slow_level); end
    cycle(0, 0, 0, 0);
    checks++; if (slow_level !== 1'b0 || fall_tick !== 1'b1 || active_half !== 16'd5 || cfg_if.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL mid_boundary got slow=%b fall=%b half=%0d ready=%b want 0 1 5 1", slow_level, fall_tick, active_half, cfg_if.cfg_ready);
    end
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 0, 0, 0);
      checks++; if (slow_level !== (i == 5) || obs !== exp_vec()) begin errors++; $display("FAIL mid_low_i%0d got slow=%b obs=%h want %b %h", i, slow_level, obs, i == 5, exp_vec()); end
    end
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 20 && running === 1'b1; i++) cycle(0, 0, 0, 0);
    checks++; if (running !== 1'b0 || slow_level !== 1'b0) begin errors++; $display("FAIL mid_stop got run=%b slow=%b want 0 0", running, slow_level); end
  endtask

  task automatic test_stop_high();
    int highs, falls;
    cycle(0, 0, 1, 4);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20 && rise_tick !== 1'b1; i++) cycle(0, 0, 0, 0);
    checks++; if (rise_tick !== 1'b1) begin errors++; $display("FAIL stop_wait_rise got %b want 1", rise_tick); end
    highs = 1; falls = 0;
    cycle(0, 1, 0, 0);
    highs += int'(slow_level);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0);
      highs += int'(slow_level);
      falls += int'(fall_tick);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL stop_model_i%0d got %h want %h", i, obs, exp_vec()); end
      if (running !== 1'b1) break;
    end
    checks++; if (highs !== 4 || falls !== 1) begin errors++; $display("FAIL stop_high_len got highs=%0d falls=%0d want 4 1", highs, falls); end
    checks++; if (running !== 1'b0 || slow_level !== 1'b0) begin errors++; $display("FAIL stop_idle got run=%b slow=%b want 0 0", running, slow_level); end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1, 3);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20 && rise_tick !== 1'b1; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 6);
    checks++; if (cfg_if.cfg_ready !== 1'b0 || slow_level !== 1'b1) begin errors++; $display("FAIL arst_pre got ready=%b slow=%b want 0 1", cfg_if.cfg_ready, slow_level); end
    #2 reset = 1'b1;
    #1;
    checks++; if (slow_level !== 1'b0 || active_half !== 16'd2 || cfg_if.cfg_ready !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL arst_async got slow=%b half=%0d ready=%b run=%b want 0 2 1 0", slow_level, active_half, cfg_if.cfg_ready, running);
    end
    model_reset();
    cycle(0, 0, 0, 0);
    reset = 1'b0;
    cycle(0, 0, 0, 0);
    checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL arst_after got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 5)));
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL rand_i%0d got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_half = '0;
    model_reset();
    test_reset();
    test_basic();
    test_start_stop_zero_cfg();
    test_edge_count();
    test_cfg_midrun();
    test_stop_high();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
